instr_fetch_decode: RTL and testbench

- Byte-stream instruction fetch/decode stage for the 8080-style core.
- Buffers incoming program bytes in a parametrised FIFO and determines each instruction's length (1-3 bytes) from its first byte.
- Assembles complete instructions, decodes them into register-file, ALU and jump control fields, and presents them with the instruction's PC through a registered valid/ready output.
- Supports flush-with-redirect for taken jumps and a sticky halt on HLT.

---
 rtl/instr_fetch_decode.sv | 210 +++++++++++++++++++++
 tb/tb_instr_fetch_decode.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - byte-stream instruction fetch/decode stage for the 8080-style core
//
// Buffers program bytes in a DEPTH-entry FIFO, sizes each instruction (1..3 bytes)
// from its first byte, and issues complete instructions with their decode and PC
// through a registered valid/ready output register.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_byte/in_valid      program byte stream in; in_ready = FIFO not full
//   flush, flush_pc       drop FIFO and output register, restart PC at flush_pc
//   out_valid/out_ready   decoded instruction handshake
//   out_pc, num_bytes     address and length of the issued instruction
//   opcode, read_addr_1, read_addr_2, write_addr, jump_en, jump_flag, immediate
//                         decoded control fields
//   halted                HLT issued, no further issue until flush/reset
module instr_fetch_decode #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter bit              HALT_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      in_byte,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [1:0]      num_bytes,
    output logic [3:0]      opcode,
    output logic [2:0]      read_addr_1,
    output logic [2:0]      read_addr_2,
    output logic [2:0]      write_addr,
    output logic            jump_en,
    output logic [2:0]      jump_flag,
    output logic [15:0]     immediate,
    output logic            halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [PC_W-1:0] pc;

    logic [7:0]  b0, b1, b2;
    logic [1:0]  len;
    logic [2:0]  rp;
    logic [3:0]  d_op;
    logic [2:0]  d_ra1, d_ra2, d_wa, d_jf;
    logic        d_jen;
    logic [15:0] d_imm;
    logic        push;
    logic        issue;

    // The three bytes at the head; only the first len of them are meaningful.
    assign b0 = mem[rd_ptr];
    assign b1 = mem[rd_ptr + AW'(1)];
    assign b2 = mem[rd_ptr + AW'(2)];
    assign rp = {1'b0, b0[5:4]};

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // The output register may be refilled in the same cycle it is drained.
    assign issue    = (count >= CW'(len)) && !halted && (!out_valid || out_ready);

    always_comb begin
        casez (b0)
            8'b00??0001, 8'b001??010, 8'b11???01?: len = 2'd3;
            8'b00???110, 8'b11???11?:              len = 2'd2;
            default:                               len = 2'd1;
        endcase
    end

    always_comb begin
        d_op  = 4'd0;
        d_ra1 = 3'd7;
        d_ra2 = 3'd7;
        d_wa  = 3'd7;
        d_jen = 1'b0;
        d_jf  = 3'd0;
        case (b0[7:6])
            2'b11: begin
                case (b0[2:1])
                    2'b00: begin
                        d_ra1 = 3'd2;
                        d_jen = 1'b1;
                    end
                    2'b01: begin
                        d_jf  = b0[5:3];
                        d_jen = b0[0];
                    end
                    2'b11:   d_op = {1'b0, b0[5:3]};
                    default: ;
                endcase
            end
            2'b10: begin
                d_op  = {1'b0, b0[5:3]};
                d_ra2 = b0[2:0];
            end
            2'b01: begin
                d_ra1 = b0[2:0];
                d_wa  = b0[5:3];
            end
            default: begin
                // Ordered: the first matching pattern wins.
                casez (b0[5:0])
                    6'b??0001: d_wa = rp;
                    6'b??1001: begin
                        d_ra1 = 3'd2;
                        d_ra2 = rp;
                        d_wa  = 3'd2;
                    end
                    6'b0??010: d_ra1 = rp;
                    6'b10?010: begin
                        d_ra1 = 3'd2;
                        d_ra2 = 3'd5;
                        d_wa  = 3'd5;
                    end
                    6'b11?010: d_ra1 = 3'd2;
                    6'b???011: begin
                        d_ra1 = rp;
                        d_wa  = rp;
                        d_op  = b0[3] ? 4'd2 : 4'd0;
                    end
                    6'b???10?: begin
                        d_ra1 = b0[5:3];
                        d_wa  = b0[5:3];
                        d_op  = b0[0] ? 4'd2 : 4'd0;
                    end
                    6'b???110: d_wa = b0[5:3];
                    6'b???111: d_op = {1'b1, b0[5:3]};
                    default:   ;
                endcase
            end
        endcase
    end

    always_comb begin
        case (len)
            2'd3:    d_imm = {b2, b1};
            2'd2:    d_imm = {8'h00, b1};
            default: d_imm = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr] <= in_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            halted      <= 1'b0;
            out_pc      <= RESET_PC;
            num_bytes   <= 2'd1;
            opcode      <= 4'd0;
            read_addr_1 <= 3'd7;
            read_addr_2 <= 3'd7;
            write_addr  <= 3'd7;
            jump_en     <= 1'b0;
            jump_flag   <= 3'd0;
            immediate   <= 16'h0000;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pc        <= flush_pc;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count + CW'(push) - (issue ? CW'(len) : CW'(0));
            if (issue) begin
                rd_ptr      <= rd_ptr + AW'(len);
                pc          <= pc + PC_W'(len);
                out_valid   <= 1'b1;
                out_pc      <= pc;
                num_bytes   <= len;
                opcode      <= d_op;
                read_addr_1 <= d_ra1;
                read_addr_2 <= d_ra2;
                write_addr  <= d_wa;
                jump_en     <= d_jen;
                jump_flag   <= d_jf;
                immediate   <= d_imm;
                if (HALT_EN && b0 == 8'h76) begin
                    halted <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - self-checking bench for instr_fetch_decode
module tb_instr_fetch_decode;

    typedef struct packed {
        logic [15:0] pc;
        logic [1:0]  nb;
        logic [3:0]  op;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [2:0]  wa;
        logic        jen;
        logic [2:0]  jf;
        logic [15:0] imm;
    } exp_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        exp_t       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [1:0]  num_bytes;
    logic [3:0]  opcode;
    logic [2:0]  read_addr_1, read_addr_2, write_addr;
    logic        jump_en;
    logic [2:0]  jump_flag;
    logic [15:0] immediate;
    logic        halted;

    logic [7:0]  in_byte_2;
    logic        in_valid_2;
    logic        in_ready_2;
    logic        flush_2;
    logic [15:0] flush_pc_2;
    logic        out_valid_2;
    logic        out_ready_2;
    logic [15:0] out_pc_2;
    logic [1:0]  num_bytes_2;
    logic [3:0]  opcode_2;
    logic [2:0]  read_addr_1_2, read_addr_2_2, write_addr_2;
    logic        jump_en_2;
    logic [2:0]  jump_flag_2;
    logic [15:0] immediate_2;
    logic        halted_2;

    logic        ready_mode;
    logic        ready_force;
    logic        rnd_bit = 1'b1;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_pc;
    exp_t        sb[$];
    vec_t        vecs[$];
    exp_t        mon_exp, mon_act;

    assign out_ready = ready_mode ? rnd_bit : ready_force;

    always #5 clk = ~clk;

    instr_fetch_decode #(.DEPTH(4), .PC_W(16), .RESET_PC(16'h0000), .HALT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .flush_pc(flush_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .num_bytes(num_bytes), .opcode(opcode), .read_addr_1(read_addr_1),
        .read_addr_2(read_addr_2), .write_addr(write_addr), .jump_en(jump_en),
        .jump_flag(jump_flag), .immediate(immediate), .halted(halted)
    );

    instr_fetch_decode #(.DEPTH(4), .PC_W(16), .RESET_PC(16'h0000), .HALT_EN(1'b0)) dut_nohalt (
        .clk(clk), .rst(rst), .in_byte(in_byte_2), .in_valid(in_valid_2), .in_ready(in_ready_2),
        .flush(flush_2), .flush_pc(flush_pc_2), .out_valid(out_valid_2), .out_ready(out_ready_2),
        .out_pc(out_pc_2), .num_bytes(num_bytes_2), .opcode(opcode_2), .read_addr_1(read_addr_1_2),
        .read_addr_2(read_addr_2_2), .write_addr(write_addr_2), .jump_en(jump_en_2),
        .jump_flag(jump_flag_2), .immediate(immediate_2), .halted(halted_2)
    );

    function automatic exp_t mk(input logic [15:0] pc, input logic [1:0] nb, input logic [3:0] op,
                                input logic [2:0] ra1, input logic [2:0] ra2, input logic [2:0] wa,
                                input logic jen, input logic [2:0] jf, input logic [15:0] imm);
        mk = {pc, nb, op, ra1, ra2, wa, jen, jf, imm};
    endfunction

    task automatic add_vec(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input exp_t e);
        vec_t v;
        v.b0 = b0;
        v.b1 = b1;
        v.b2 = b2;
        v.e  = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic push_byte(input logic [7:0] b);
        int guard;
        guard    = 0;
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: in_ready stuck at 0 for byte %h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        e    = v.e;
        e.pc = exp_pc;
        sb.push_back(e);
        exp_pc = exp_pc + 16'(v.e.nb);
        push_byte(v.b0);
        if (v.e.nb >= 2'd2) push_byte(v.b1);
        if (v.e.nb == 2'd3) push_byte(v.b2);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard: every accepted output is compared against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !flush && out_valid && out_ready) begin
                tests++;
                mon_act = {out_pc, num_bytes, opcode, read_addr_1, read_addr_2, write_addr,
                           jump_en, jump_flag, immediate};
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got instr at pc %h, expected no output", out_pc);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_act !== mon_exp) begin
                        fails++;
                        $display("FAIL sb_instr: got pc=%h nb=%0d op=%0d ra1=%0d ra2=%0d wa=%0d jen=%0d jf=%0d imm=%h, expected pc=%h nb=%0d op=%0d ra1=%0d ra2=%0d wa=%0d jen=%0d jf=%0d imm=%h",
                                 mon_act.pc, mon_act.nb, mon_act.op, mon_act.ra1, mon_act.ra2, mon_act.wa,
                                 mon_act.jen, mon_act.jf, mon_act.imm,
                                 mon_exp.pc, mon_exp.nb, mon_exp.op, mon_exp.ra1, mon_exp.ra2, mon_exp.wa,
                                 mon_exp.jen, mon_exp.jf, mon_exp.imm);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_byte = 8'h00; in_valid = 1'b0; flush = 1'b0; flush_pc = 16'h0000;
        in_byte_2 = 8'h00; in_valid_2 = 1'b0; flush_2 = 1'b0; flush_pc_2 = 16'h0000; out_ready_2 = 1'b1;
        ready_mode = 1'b0; ready_force = 1'b1; exp_pc = 16'h0000;

        //        b0     b1     b2          pc  nb  op  ra1 ra2 wa  jen jf  imm
        add_vec(8'h80, 8'h00, 8'h00, mk(0, 1, 0, 7, 0, 7, 0, 0, 16'h0000));
        add_vec(8'h3E, 8'h55, 8'h00, mk(0, 2, 0, 7, 7, 7, 0, 0, 16'h0055));
        add_vec(8'h21, 8'h00, 8'h20, mk(0, 3, 0, 7, 7, 2, 0, 0, 16'h2000));
        add_vec(8'h09, 8'h00, 8'h00, mk(0, 1, 0, 2, 0, 2, 0, 0, 16'h0000));
        add_vec(8'h0A, 8'h00, 8'h00, mk(0, 1, 0, 0, 7, 7, 0, 0, 16'h0000));
        add_vec(8'h22, 8'h78, 8'h56, mk(0, 3, 0, 2, 5, 5, 0, 0, 16'h5678));
        add_vec(8'h3A, 8'hCD, 8'hAB, mk(0, 3, 0, 2, 7, 7, 0, 0, 16'hABCD));
        add_vec(8'h03, 8'h00, 8'h00, mk(0, 1, 0, 0, 7, 0, 0, 0, 16'h0000));
        add_vec(8'h2B, 8'h00, 8'h00, mk(0, 1, 2, 2, 7, 2, 0, 0, 16'h0000));
        add_vec(8'h17, 8'h00, 8'h00, mk(0, 1, 10, 7, 7, 7, 0, 0, 16'h0000));
        add_vec(8'hE9, 8'h00, 8'h00, mk(0, 1, 0, 2, 7, 7, 1, 0, 16'h0000));
        add_vec(8'hCA, 8'h00, 8'h10, mk(0, 3, 0, 7, 7, 7, 0, 1, 16'h1000));
        add_vec(8'hDB, 8'h01, 8'h02, mk(0, 3, 0, 7, 7, 7, 1, 3, 16'h0201));
        add_vec(8'hE6, 8'h0F, 8'h00, mk(0, 2, 4, 7, 7, 7, 0, 0, 16'h000F));
        add_vec(8'hFE, 8'h10, 8'h00, mk(0, 2, 7, 7, 7, 7, 0, 0, 16'h0010));
        add_vec(8'hCD, 8'h00, 8'h00, mk(0, 1, 0, 7, 7, 7, 0, 0, 16'h0000));
        add_vec(8'h00, 8'h00, 8'h00, mk(0, 1, 0, 7, 7, 7, 0, 0, 16'h0000));
        add_vec(8'h10, 8'h00, 8'h00, mk(0, 1, 0, 7, 7, 7, 0, 0, 16'h0000));
        add_vec(8'h47, 8'h00, 8'h00, mk(0, 1, 0, 7, 7, 0, 0, 0, 16'h0000));
        add_vec(8'h9A, 8'h00, 8'h00, mk(0, 1, 3, 7, 2, 7, 0, 0, 16'h0000));
        add_vec(8'h36, 8'h99, 8'h00, mk(0, 2, 0, 7, 7, 6, 0, 0, 16'h0099));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_num_bytes", 32'(num_bytes), 32'd1);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_addrs", {20'd0, read_addr_1, read_addr_2, write_addr, 3'd0}, {20'd0, 9'o777, 3'd0});
        check("rst_jump", {28'd0, jump_en, jump_flag}, 32'd0);
        check("rst_immediate", 32'(immediate), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: a 3-byte jump only issues one edge after its last byte lands.
        sb.push_back(mk(exp_pc, 3, 0, 7, 7, 7, 1, 0, 16'h1234));
        exp_pc = exp_pc + 16'd3;
        push_byte(8'hC3);
        @(negedge clk); check("lat_after_b1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        push_byte(8'h34);
        @(negedge clk); check("lat_after_b2", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        push_byte(8'h12);
        @(negedge clk); check("lat_not_early", 32'(out_valid), 32'd0);
        @(negedge clk); check("lat_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        drain();

        ready_mode = 1'b1;
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        ready_mode = 1'b0;
        ready_force = 1'b1;
        drain();

        // Stall: output holds the first op while the FIFO fills behind it.
        ready_force = 1'b0;
        @(posedge clk); #1;
        sb.push_back(mk(exp_pc,         1, 0, 0, 7, 0, 0, 0, 16'h0000));
        sb.push_back(mk(exp_pc + 16'd1, 1, 2, 0, 7, 0, 0, 0, 16'h0000));
        sb.push_back(mk(exp_pc + 16'd2, 1, 0, 7, 7, 7, 0, 0, 16'h0000));
        sb.push_back(mk(exp_pc + 16'd3, 1, 2, 7, 7, 7, 0, 0, 16'h0000));
        sb.push_back(mk(exp_pc + 16'd4, 1, 8, 7, 7, 7, 0, 0, 16'h0000));
        push_byte(8'h04);
        push_byte(8'h05);
        push_byte(8'h3C);
        push_byte(8'h3D);
        push_byte(8'h07);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_pc", 32'(out_pc), 32'(exp_pc));
        check("stall_op", 32'(opcode), 32'd0);
        check("stall_ra1_wa", {26'd0, read_addr_1, write_addr}, 32'd0);
        exp_pc = exp_pc + 16'd5;
        @(posedge clk); #1;
        ready_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b2b_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        check("b2b_done", 32'(out_valid), 32'd0);
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drain();

        // Flush drops a partial LXI and the byte presented during the flush.
        sb.push_back(mk(exp_pc, 2, 0, 7, 7, 7, 0, 0, 16'h0055));
        push_byte(8'h3E);
        push_byte(8'h55);
        push_byte(8'h21);
        push_byte(8'h00);
        drain();
        flush = 1'b1; flush_pc = 16'h0100; in_byte = 8'hAA; in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_pc = 16'h0100;
        sb.push_back(mk(exp_pc, 1, 0, 7, 7, 7, 0, 0, 16'h0000));
        exp_pc = exp_pc + 16'd1;
        push_byte(8'h00);
        drain();

        // Halt: HLT issues, later bytes wait; FIFO still fills; flush releases.
        sb.push_back(mk(exp_pc, 1, 0, 6, 7, 6, 0, 0, 16'h0000));
        push_byte(8'h76);
        push_byte(8'h80);
        repeat (4) @(negedge clk);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_no_issue", 32'(out_valid), 32'd0);
        check("halt_hlt_seen", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        push_byte(8'h00);
        push_byte(8'h00);
        push_byte(8'h00);
        @(negedge clk);
        check("halt_fifo_full", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b1; flush_pc = 16'h0200;
        @(negedge clk);
        check("flush_old_count", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_unhalt", 32'(halted), 32'd0);
        check("flush_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        exp_pc = 16'h0200;
        sb.push_back(mk(exp_pc, 1, 0, 7, 0, 7, 0, 0, 16'h0000));
        exp_pc = exp_pc + 16'd1;
        push_byte(8'h80);
        drain();

        // HALT_EN=0: HLT is an ordinary MOV and the next op follows.
        in_byte_2 = 8'h76; in_valid_2 = 1'b1;
        @(posedge clk); #1;
        in_byte_2 = 8'h80;
        @(posedge clk); #1;
        in_valid_2 = 1'b0;
        @(negedge clk);
        check("nohalt_hlt_valid", 32'(out_valid_2), 32'd1);
        check("nohalt_hlt_addrs", {26'd0, read_addr_1_2, write_addr_2}, {26'd0, 3'd6, 3'd6});
        @(negedge clk);
        check("nohalt_next_valid", 32'(out_valid_2), 32'd1);
        check("nohalt_next_ra2", 32'(read_addr_2_2), 32'd0);
        check("nohalt_next_pc", 32'(out_pc_2), 32'd1);
        check("nohalt_halted", 32'(halted_2), 32'd0);
        @(posedge clk); #1;

        // Reset while a 3-byte instruction is stalled at the output.
        ready_force = 1'b0;
        push_byte(8'hC3);
        push_byte(8'h11);
        push_byte(8'h22);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        check("rst_pre_nb", 32'(num_bytes), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        ready_force = 1'b1;
        exp_pc = 16'h0000;
        sb.push_back(mk(exp_pc, 1, 0, 7, 0, 7, 0, 0, 16'h0000));
        push_byte(8'h80);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
